// File: rtl/dac_playback_ctrl.sv
// Waveform playback sequencer: sample RAM plus a window/repeat streamer feeding the DAC.
// Read path is RAM register -> output register, so the first sample lands two edges after start.
module dac_playback_ctrl #(
  parameter int bits   = 16,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [bits-1:0]   wr_data,
  input  logic [ADDR_W:0]   cfg_len,
  input  logic [7:0]        cfg_reps,
  input  logic [bits-1:0]   cfg_idle,
  input  logic              start,
  input  logic              stop,
  output logic [bits-1:0]   m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRIME = 2'd1;
  localparam logic [1:0] S_PLAY  = 2'd2;

  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ONE_L   = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A   = ADDR_W'(1);

  logic [bits-1:0]   mem [DEPTH];
  logic [bits-1:0]   rd_data;
  logic [1:0]        state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   len_q;
  logic [7:0]        reps_q, rep;
  logic              rd_last, out_last;
  logic              len_ok, wrap, last_rd;

  // Read-before-write: a same-address collision returns the old sample.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[addr];
  end

  assign len_ok  = (cfg_len != '0) && (cfg_len <= DEPTH_L);
  assign wrap    = ({1'b0, addr} == (len_q - ONE_L));
  // Final read of the final repetition; it reaches the output one edge later.
  assign last_rd = wrap && (reps_q != 8'd0) && (rep == reps_q - 8'd1);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      addr          <= '0;
      len_q         <= '0;
      reps_q        <= '0;
      rep           <= '0;
      rd_last       <= 1'b0;
      out_last      <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          m_axis_tdata  <= cfg_idle;
          m_axis_tvalid <= 1'b0;
          if (start && !stop) begin
            if (len_ok) begin
              state    <= S_PRIME;
              len_q    <= cfg_len;
              reps_q   <= cfg_reps;
              addr     <= '0;
              rep      <= '0;
              rd_last  <= 1'b0;
              out_last <= 1'b0;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_PRIME, S_PLAY: begin
          if (stop || (state == S_PLAY && out_last)) begin
            state         <= S_IDLE;
            m_axis_tdata  <= cfg_idle;
            m_axis_tvalid <= 1'b0;
            done          <= 1'b1;
          end else begin
            if (state == S_PLAY) begin
              m_axis_tdata  <= rd_data;
              m_axis_tvalid <= 1'b1;
              out_last      <= rd_last;
            end
            state   <= S_PLAY;
            rd_last <= last_rd;
            addr    <= wrap ? '0 : addr + ONE_A;
            if (wrap) rep <= rep + 8'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Self-checking bench for dac_playback_ctrl; expected samples come from a memory model and a read queue.
module tb_dac_playback_ctrl;
  localparam int BITS  = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wr_en = 1'b0;
  logic [AW-1:0]   wr_addr = '0;
  logic [BITS-1:0] wr_data = '0;
  logic [AW:0]     cfg_len = '0;
  logic [7:0]      cfg_reps = '0;
  logic [BITS-1:0] cfg_idle = 16'hA5A5;
  logic            start = 1'b0;
  logic            stop = 1'b0;
  logic [BITS-1:0] m_axis_tdata;
  logic            m_axis_tvalid, busy, done, err;

  logic [BITS-1:0] mem_m [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  dac_playback_ctrl #(.bits(BITS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cfg_len(cfg_len), .cfg_reps(cfg_reps), .cfg_idle(cfg_idle),
    .start(start), .stop(stop), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic wr(input int a, input logic [BITS-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    @(posedge clk);
    mem_m[a] = d;
    #1;
    wr_en = 1'b0;
  endtask

  // Expected sample k is mem[k % len] as it stood when read at E1+k, shown after E2+k.
  task automatic play(input int len, input int reps, input int stop_after, input int wr_c,
                      input int wr_a, input logic [BITS-1:0] wr_d, input bit hold_start);
    logic [BITS-1:0] rdq[$];
    logic [BITS-1:0] e, idle;
    int n, stop_c;
    bit finished;
    finished = 1'b0;
    n      = (reps == 0) ? 100000 : len * reps;
    stop_c = (stop_after < 0) ? -1 : stop_after + 2;
    cfg_len = len[AW:0]; cfg_reps = reps[7:0]; start = 1'b1; stop = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({m_axis_tvalid, busy, done, err} !== 4'b0100) begin
      n_fail++;
      $display("FAIL accept len=%0d: tvalid/busy/done/err=%b exp 0100", len, {m_axis_tvalid, busy, done, err});
    end
    cfg_len = 7'($urandom); cfg_reps = 8'($urandom);
    for (int c = 1; c < 4000; c++) begin
      wr_en = (c == wr_c); wr_addr = AW'(wr_a); wr_data = wr_d;
      stop  = (c == stop_c);
      start = hold_start && (c <= n);
      cfg_idle = 16'($urandom); idle = cfg_idle;
      @(posedge clk);
      rdq.push_back(mem_m[(c - 1) % len]);
      if (wr_en) mem_m[wr_a] = wr_d;
      #1;
      wr_en = 1'b0; stop = 1'b0;
      if (c == stop_c || c == n + 2) begin
        n_checks++;
        if ({m_axis_tdata, m_axis_tvalid, busy, done, err} !== {idle, 4'b0010}) begin
          n_fail++;
          $display("FAIL end c=%0d: data=%h v/b/d/e=%b exp data=%h 0010", c, m_axis_tdata,
                   {m_axis_tvalid, busy, done, err}, idle);
        end
        finished = 1'b1;
        break;
      end else if (c == 1) begin
        n_checks++;
        if ({m_axis_tvalid, busy, done, err} !== 4'b0100) begin
          n_fail++;
          $display("FAIL prime: v/b/d/e=%b exp 0100", {m_axis_tvalid, busy, done, err});
        end
      end else begin
        e = rdq.pop_front();
        n_checks++;
        if ({m_axis_tdata, m_axis_tvalid, busy, done, err} !== {e, 4'b1100}) begin
          n_fail++;
          $display("FAIL sample %0d: data=%h v/b/d/e=%b exp data=%h 1100", c - 2, m_axis_tdata,
                   {m_axis_tvalid, busy, done, err}, e);
        end
      end
    end
    if (!finished) begin
      n_checks++; n_fail++;
      $display("FAIL timeout: playback never ended (len=%0d reps=%0d)", len, reps);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({m_axis_tdata, m_axis_tvalid, busy, done, err} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset: got %h exp 0", {m_axis_tdata, m_axis_tvalid, busy, done, err});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if ({m_axis_tdata, m_axis_tvalid, busy} !== {cfg_idle, 2'b00}) begin
      n_fail++;
      $display("FAIL idle_code: data=%h exp %h", m_axis_tdata, cfg_idle);
    end
  endtask

  task automatic test_basic;
    wr(0, 16'h0001); wr(1, 16'h0002); wr(2, 16'h7FFF); wr(3, 16'h8000);
    play(4, 2, -1, -1, 0, '0, 1'b0);
  endtask

  task automatic test_len1;
    wr(0, 16'h1234);
    play(1, 3, -1, -1, 0, '0, 1'b0);
  endtask

  task automatic test_infinite_stop;
    for (int i = 0; i < 3; i++) wr(i, 16'($urandom));
    play(3, 0, 20, -1, 0, '0, 1'b0);
  endtask

  task automatic test_err;
    cfg_len = 7'd0; start = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({m_axis_tvalid, busy, done, err} !== 4'b0001) begin
        n_fail++;
        $display("FAIL err_len%0d: v/b/d/e=%b exp 0001", cfg_len, {m_axis_tvalid, busy, done, err});
      end
      start = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if ({busy, err} !== 2'b00) begin
        n_fail++;
        $display("FAIL err_pulse: busy/err=%b exp 00", {busy, err});
      end
      cfg_len = 7'(DEPTH + 1); start = 1'b1;
    end
    cfg_len = 7'd4; start = 1'b1; stop = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      start = 1'b0; stop = 1'b0;
      n_checks++;
      if ({m_axis_tvalid, busy, done, err} !== 4'b0000) begin
        n_fail++;
        $display("FAIL start_stop_idle: v/b/d/e=%b exp 0000", {m_axis_tvalid, busy, done, err});
      end
    end
  endtask

  task automatic test_collision;
    for (int i = 0; i < 4; i++) wr(i, 16'h1000 + 16'(i));
    play(4, 0, 12, 3, 2, 16'h5555, 1'b0);
  endtask

  task automatic test_reset_mid;
    cfg_len = 7'd4; cfg_reps = 8'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if ({m_axis_tdata, m_axis_tvalid, busy, done, err} !== 20'h0) begin
      n_fail++;
      $display("FAIL reset_mid: got %h exp 0", {m_axis_tdata, m_axis_tvalid, busy, done, err});
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({m_axis_tdata, m_axis_tvalid, busy, done, err} !== {cfg_idle, 4'b0000}) begin
        n_fail++;
        $display("FAIL post_reset: data=%h v/b/d/e=%b exp %h 0000", m_axis_tdata,
                 {m_axis_tvalid, busy, done, err}, cfg_idle);
      end
    end
  endtask

  task automatic test_busy_start;
    play(4, 2, -1, -1, 0, '0, 1'b1);
  endtask

  task automatic test_back_to_back;
    play(2, 1, -1, -1, 0, '0, 1'b0);
    play(3, 2, -1, -1, 0, '0, 1'b0);
  endtask

  task automatic test_random;
    for (int i = 0; i < DEPTH; i++) wr(i, 16'($urandom));
    for (int t = 0; t < 4; t++)
      play(int'($urandom_range(1, DEPTH)), int'($urandom_range(1, 3)), -1, -1, 0, '0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len1();
    test_infinite_stop();
    test_err();
    test_collision();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
